// File: rtl/inst_mem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
// Imported by the loader top and its word assembler.
package inst_mem_pkg;

  localparam int DEPTH_WORDS = 128;
  localparam int ADDR_W      = 7;
  localparam int LEN_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/inst_word_assembler.sv
// Big-endian 4-byte shift register with byte counter.
// word_ready flags the byte that completes a word.
module inst_word_assembler
  import inst_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_ready
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  // next word, completion flag and counter update
  always_comb begin
    word_next  = {word_q[23:0], byte_in};
    word_ready = shift_en && (cnt_q == 2'd3);
    cnt_d      = cnt_q;
    word_d     = word_q;
    if (clear) begin
      cnt_d = 2'd0;
    end else if (shift_en) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = word_next;
    end
  end

  // shift register and byte counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Streams a length-prefixed, checksummed program image into
// instruction RAM one word at a time, holding the CPU meanwhile.
module inst_mem_loader
  import inst_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic [31:0]       wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              xfer;
  logic              asm_clear;
  logic              asm_shift;
  logic [31:0]       asm_word;
  logic              asm_ready;
  logic [LEN_W-1:0]  n_len;
  logic              last_word;

  assign xfer      = rx_valid && rx_ready_q;
  assign asm_shift = (state_q == S_DATA) && xfer;
  assign last_word = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

  inst_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .shift_en   (asm_shift),
    .byte_in    (rx_data),
    .word_next  (asm_word),
    .word_ready (asm_ready)
  );

  // load sequencing; outputs are computed for the next state
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    we_d      = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    done_d    = done_q;
    error_d   = error_q;
    asm_clear = 1'b0;
    n_len     = {len_q[LEN_W-1:8], rx_data};
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_LEN_HI;
          done_d    = 1'b0;
          error_d   = 1'b0;
          idx_d     = '0;
          sum_d     = 8'd0;
          asm_clear = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d   = {rx_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = n_len;
          if (n_len == '0 ||
              n_len > LEN_W'(DEPTH_WORDS)) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          sum_d = sum_q + rx_data;
          if (asm_ready) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            wa_d    = {{(30-ADDR_W){1'b0}}, idx_q, 2'b00};
            wd_d    = asm_word;
          end
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_d = S_CSUM;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (rx_data == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    rx_ready_d = (state_d == S_LEN_HI) ||
                 (state_d == S_LEN_LO) ||
                 (state_d == S_DATA) ||
                 (state_d == S_CSUM);
    cpu_hold_d = (state_d != S_IDLE) &&
                 (state_d != S_DONE);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= 8'd0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      wa_q       <= 32'd0;
      wd_q       <= 32'd0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign we       = we_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: byte-stream driver,
// write logger and a single check task.
module tb_inst_mem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];

  inst_mem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && we) begin
      wa_log.push_back(wa);
      wd_log.push_back(wd);
      check("wr_rdy", {31'd0, rx_ready}, 32'd0);
      check("wr_hold", {31'd0, cpu_hold}, 32'd1);
    end
  end

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rdy_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input bq_t img,
                            input int maxgap);
    foreach (img[i])
      send_byte(img[i], (maxgap > 0) ?
                int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wa_log.delete();
    wd_log.delete();
  endtask

  task automatic check_img1_writes(input string t);
    check({t, "_nwr"}, wa_log.size(), 32'd2);
    if (wa_log.size() == 2) begin
      check({t, "_wa0"}, wa_log[0], 32'h000);
      check({t, "_wd0"}, wd_log[0], 32'h12345678);
      check({t, "_wa1"}, wa_log[1], 32'h004);
      check({t, "_wd1"}, wd_log[1], 32'h9ABCDEF0);
    end
  endtask

  task automatic check_flags(input string t,
                             input logic d,
                             input logic e,
                             input logic h);
    check({t, "_done"}, {31'd0, done}, {31'd0, d});
    check({t, "_err"}, {31'd0, error}, {31'd0, e});
    check({t, "_hold"}, {31'd0, cpu_hold}, {31'd0, h});
  endtask

  initial begin
    bq_t img1, img_bad, big;
    img1 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
             8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h38};
    img_bad = img1;
    img_bad[10] = 8'h39;

    repeat (3) @(negedge clk);
    check("rst_rdy", {31'd0, rx_ready}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_wa", wa, 32'd0);
    check("rst_wd", wd, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // 1: good image
    clear_log();
    pulse_start();
    check("t1_rdy", {31'd0, rx_ready}, 32'd1);
    check("t1_hold0", {31'd0, cpu_hold}, 32'd1);
    send_bytes(img1, 0);
    check_img1_writes("t1");
    check_flags("t1", 1'b1, 1'b0, 1'b0);
    check("t1_rdy_end", {31'd0, rx_ready}, 32'd0);

    // 2: bad checksum
    clear_log();
    pulse_start();
    send_bytes(img_bad, 0);
    check_img1_writes("t2");
    check_flags("t2", 1'b0, 1'b1, 1'b1);

    // 3: illegal lengths, then full-depth image
    clear_log();
    pulse_start();
    send_bytes('{8'h00, 8'h00}, 0);
    repeat (3) @(negedge clk);
    check_flags("t3z", 1'b0, 1'b1, 1'b1);
    check("t3z_rdy", {31'd0, rx_ready}, 32'd0);
    pulse_start();
    send_bytes('{8'h00, 8'h81}, 0);
    repeat (3) @(negedge clk);
    check_flags("t3o", 1'b0, 1'b1, 1'b1);
    check("t3_nwr", wa_log.size(), 32'd0);

    big = '{8'h00, 8'h80};
    for (int i = 0; i < 512; i++) big.push_back(i[7:0]);
    big.push_back(8'h00);
    pulse_start();
    send_bytes(big, 0);
    check("t3b_nwr", wa_log.size(), 32'd128);
    if (wa_log.size() == 128) begin
      check("t3b_wd0", wd_log[0], 32'h00010203);
      check("t3b_wa_last", wa_log[127], 32'h1FC);
      check("t3b_wd_last", wd_log[127], 32'hFCFDFEFF);
    end
    check_flags("t3b", 1'b1, 1'b0, 1'b0);

    // 4: random gaps between bytes
    clear_log();
    pulse_start();
    send_bytes(img1, 5);
    check_img1_writes("t4");
    check_flags("t4", 1'b1, 1'b0, 1'b0);

    // 5: reset mid-load after 6 data bytes
    clear_log();
    pulse_start();
    send_bytes('{8'h00, 8'h02, 8'h12, 8'h34, 8'h56,
                 8'h78, 8'h9A, 8'hBC}, 0);
    check("t5_pre_wd", wd, 32'h12345678);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rdy", {31'd0, rx_ready}, 32'd0);
    check("t5_we", {31'd0, we}, 32'd0);
    check("t5_wa", wa, 32'd0);
    check("t5_wd", wd, 32'd0);
    check_flags("t5", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    clear_log();
    pulse_start();
    send_bytes(img1, 0);
    check_img1_writes("t5r");
    check_flags("t5r", 1'b1, 1'b0, 1'b0);

    // 6: start during DATA ignored; start in DONE restarts
    clear_log();
    pulse_start();
    send_bytes('{8'h00, 8'h02, 8'h12, 8'h34}, 0);
    pulse_start();
    check("t6_rdy", {31'd0, rx_ready}, 32'd1);
    send_bytes('{8'h56, 8'h78, 8'h9A, 8'hBC,
                 8'hDE, 8'hF0, 8'h38}, 0);
    check_img1_writes("t6");
    check_flags("t6", 1'b1, 1'b0, 1'b0);
    clear_log();
    pulse_start();
    check_flags("t6s", 1'b0, 1'b0, 1'b1);
    check("t6s_rdy", {31'd0, rx_ready}, 32'd1);
    send_bytes(img1, 0);
    check_img1_writes("t6n");
    check_flags("t6n", 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
